// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT S-box layer: the forward and inverse
// 4-bit substitution tables, mode encodings, FSM state type and a lookup helper.
package present_pkg;

  // Mode encodings carried alongside each block
  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;

  // Forward PRESENT S-box, indexed by the input nibble
  localparam logic [3:0] SBOX_FWD [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  // Inverse PRESENT S-box, indexed by the input nibble
  localparam logic [3:0] SBOX_INV [16] = '{
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  // Control states of the iterative substitution engine
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Single-nibble substitution in either direction
  function automatic logic [3:0] sbox_lookup(input logic [3:0] nibble, input logic mode);
    logic [3:0] result;
    if (mode == MODE_INV) begin
      result = SBOX_INV[nibble];
    end else begin
      result = SBOX_FWD[nibble];
    end
    return result;
  endfunction

endpackage

// File: rtl/present_sbox4.sv
// One combinational 4-bit PRESENT S-box with a forward/inverse select.
module present_sbox4
  import present_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       mode,
  output logic [3:0] result
);

  // Pure table lookup; the mode chooses which of the two tables is used
  always_comb begin
    result = sbox_lookup(nibble, mode);
  end

endmodule

// File: rtl/present_sbox_layer.sv
// Iterative PRESENT S-box layer. A block is captured, then LANES nibbles are
// substituted in place per cycle, lowest group first, until every nibble has
// been substituted exactly once. The result is held until downstream takes it.
module present_sbox_layer
  import present_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int LANES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Bits handled per cycle, number of cycles per block, and counter sizing.
  // A single-group configuration still keeps a 1-bit counter.
  localparam int GW      = 4 * LANES;
  localparam int NGROUPS = WIDTH / GW;
  localparam int CW      = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam logic [CW-1:0] LAST_GRP = CW'(NGROUPS - 1);

  state_t           state;
  logic [CW-1:0]    grp;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_next;
  logic             mode;
  logic [GW-1:0]    grp_in;
  logic [GW-1:0]    grp_out;

  // Pick the nibble group addressed by the counter out of the working register
  always_comb begin
    grp_in = '0;
    for (int g = 0; g < NGROUPS; g++) begin
      if (grp == CW'(g)) begin
        grp_in = work[g*GW +: GW];
      end
    end
  end

  // LANES parallel S-boxes, all using the mode captured with the block
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    present_sbox4 u_sbox (
      .nibble (grp_in[4*l +: 4]),
      .mode   (mode),
      .result (grp_out[4*l +: 4])
    );
  end

  // Write the substituted group back into its own position, leave the rest alone
  always_comb begin
    work_next = work;
    for (int g = 0; g < NGROUPS; g++) begin
      if (grp == CW'(g)) begin
        work_next[g*GW +: GW] = grp_out;
      end
    end
  end

  // Control FSM plus the working register; the counter parks on the last
  // group when leaving RUN so no extra substitution can ever happen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grp   <= '0;
      work  <= '0;
      mode  <= MODE_FWD;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= in_data;
            mode  <= in_mode;
            grp   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          work <= work_next;
          if (grp == LAST_GRP) begin
            state <= DONE;
          end else begin
            grp <= grp + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Handshake flags decode straight from the state register; the working
  // register is always visible and only meaningful while out_valid is high
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = work;

endmodule
